// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The counter width is sized for the largest legal outstanding window.
package mem_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t PORT_FETCH = 1'b0;
    localparam req_id_t PORT_DATA  = 1'b1;

    localparam int unsigned MAX_OUTSTANDING_LIMIT = 4;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING_LIMIT + 1);

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unanswered transactions.
// Push is ignored when full and pop is ignored when empty.
module arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output req_id_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

    req_id_t            slots [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [FCNT_W-1:0]  count_q;
    logic               push_ok;
    logic               pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == FCNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = slots[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slots[i] <= PORT_FETCH;
            end
        end else begin
            if (push_ok) begin
                slots[wr_ptr_q] <= push_id;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_q + FCNT_W'(push_ok) - FCNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and data (port 1), with grant locking under back-pressure and in-order response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          rq_valid,
    output logic [1:0]          rq_ready,
    input  logic [1:0]          rq_we,
    input  logic [2*ADDR_W-1:0] rq_addr,
    input  logic [2*DATA_W-1:0] rq_wdata,
    output logic [1:0]          rs_valid,
    output logic [DATA_W-1:0]   rs_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_data,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic [2:0]          outstanding,
    output logic                err_spurious
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    req_id_t          rr_last_q;
    logic             lock_valid_q;
    req_id_t          lock_id_q;
    logic [CNT_W-1:0] outstanding_q;
    logic             err_q;

    req_id_t grant;
    logic    issue_ok;
    logic    handshake;
    logic    pop;
    logic    spurious;
    logic    fifo_full;
    logic    fifo_empty;
    req_id_t fifo_head;

    always_comb begin
        grant = PORT_FETCH;
        if (lock_valid_q) begin
            grant = lock_id_q;
        end else if (rq_valid == 2'b11) begin
            grant = ~rr_last_q;
        end else if (rq_valid[PORT_DATA]) begin
            grant = PORT_DATA;
        end
    end

    // Registered count gates issue, so a same-cycle pop never frees a slot early.
    assign issue_ok      = (outstanding_q < MAX_CNT) & ~fifo_full;
    assign mem_req_valid = reset & (lock_valid_q | (|rq_valid)) & issue_ok;
    assign handshake     = mem_req_valid & mem_req_ready;
    assign pop           = mem_resp_valid & ~fifo_empty;
    assign spurious      = mem_resp_valid & fifo_empty;
    assign outstanding   = outstanding_q;
    assign err_spurious  = err_q;

    always_comb begin
        rq_ready        = '0;
        rq_ready[grant] = handshake;
        mem_req_we      = 1'b0;
        mem_req_addr    = '0;
        mem_req_data    = '0;
        if (mem_req_valid) begin
            mem_req_we   = rq_we[grant];
            mem_req_addr = grant ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
            mem_req_data = grant ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
        end
    end

    always_comb begin
        rs_valid = '0;
        rs_data  = '0;
        if (pop) begin
            rs_valid[fifo_head] = 1'b1;
            rs_data             = mem_resp_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_last_q     <= PORT_DATA;
            lock_valid_q  <= 1'b0;
            lock_id_q     <= PORT_FETCH;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (handshake) begin
                rr_last_q    <= grant;
                lock_valid_q <= 1'b0;
            end else if (mem_req_valid) begin
                lock_valid_q <= 1'b1;
                lock_id_q    <= grant;
            end
            outstanding_q <= outstanding_q + CNT_W'(handshake) - CNT_W'(pop);
            if (spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (handshake),
        .push_id (grant),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for contention, back-pressure lock and asynchronous reset.
module tb_mem_port_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] W0 = 32'h1234_5678;
    localparam logic [31:0] W1 = 32'h5555_0001;

    logic        clock;
    logic        reset;
    logic [1:0]  rq_valid;
    logic [1:0]  rq_ready;
    logic [1:0]  rq_we;
    logic [63:0] rq_addr;
    logic [63:0] rq_wdata;
    logic [1:0]  rs_valid;
    logic [31:0] rs_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic [2:0]  outstanding;
    logic        err_spurious;

    int n_vec;
    int n_bad;

    assign rq_we    = 2'b10;
    assign rq_addr  = {A1, A0};
    assign rq_wdata = {W1, W0};

    mem_port_arbiter #(
        .MAX_OUTSTANDING (2),
        .ADDR_W          (32),
        .DATA_W          (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rq_valid       (rq_valid),
        .rq_ready       (rq_ready),
        .rq_we          (rq_we),
        .rq_addr        (rq_addr),
        .rq_wdata       (rq_wdata),
        .rs_valid       (rs_valid),
        .rs_data        (rs_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .outstanding    (outstanding),
        .err_spurious   (err_spurious)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  v;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic [1:0]  e_rqr;
        logic        e_mv;
        logic        e_g;
        logic [1:0]  e_rsv;
        logic [31:0] e_rsd;
        logic [2:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic [1:0] v, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic [1:0] rqr, input logic mv,
                                input logic g, input logic [1:0] rsv, input logic [31:0] rsd,
                                input logic [2:0] out, input logic err);
        vec_t t;
        t.v = v; t.rdy = rdy; t.rv = rv; t.rd = rd;
        t.e_rqr = rqr; t.e_mv = mv; t.e_g = g; t.e_rsv = rsv; t.e_rsd = rsd;
        t.e_out = out; t.e_err = err;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic rdy, input logic rv,
                         input logic [31:0] rd);
        @(negedge clock);
        rq_valid       = v;
        mem_req_ready  = rdy;
        mem_resp_valid = rv;
        mem_resp_data  = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        rq_valid = 2'b00; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    function automatic logic [127:0] all_outputs();
        return {22'd0, rq_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_data,
                rs_valid, rs_data, outstanding, err_spurious};
    endfunction

    initial begin
        logic [64:0] exp_fields;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        rq_valid = 2'b00; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        //            v    rdy rv  rd            rqr   mv g  rsv   rsd           out err
        tbl[0]  = mk(2'b01, 1, 0, 32'h0,        2'b01, 1, 0, 2'b00, 32'h0,        0, 0);
        tbl[1]  = mk(2'b00, 1, 1, 32'hDEADBEEF, 2'b00, 0, 0, 2'b01, 32'hDEADBEEF, 1, 0);
        tbl[2]  = mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 0, 2'b00, 32'h0,        0, 0);
        tbl[3]  = mk(2'b11, 1, 0, 32'h0,        2'b10, 1, 1, 2'b00, 32'h0,        0, 0);
        tbl[4]  = mk(2'b11, 1, 1, 32'h11,       2'b01, 1, 0, 2'b10, 32'h11,       1, 0);
        tbl[5]  = mk(2'b11, 1, 1, 32'h22,       2'b10, 1, 1, 2'b01, 32'h22,       1, 0);
        tbl[6]  = mk(2'b00, 0, 1, 32'h33,       2'b00, 0, 0, 2'b10, 32'h33,       1, 0);
        tbl[7]  = mk(2'b01, 1, 0, 32'h0,        2'b01, 1, 0, 2'b00, 32'h0,        0, 0);
        tbl[8]  = mk(2'b10, 1, 0, 32'h0,        2'b10, 1, 1, 2'b00, 32'h0,        1, 0);
        tbl[9]  = mk(2'b11, 1, 0, 32'h0,        2'b00, 0, 0, 2'b00, 32'h0,        2, 0);
        tbl[10] = mk(2'b11, 1, 1, 32'h44,       2'b00, 0, 0, 2'b01, 32'h44,       2, 0);
        tbl[11] = mk(2'b11, 1, 0, 32'h0,        2'b01, 1, 0, 2'b00, 32'h0,        1, 0);
        tbl[12] = mk(2'b00, 0, 1, 32'h55,       2'b00, 0, 0, 2'b10, 32'h55,       2, 0);
        tbl[13] = mk(2'b00, 0, 1, 32'h66,       2'b00, 0, 0, 2'b01, 32'h66,       1, 0);
        tbl[14] = mk(2'b00, 0, 1, 32'h77,       2'b00, 0, 0, 2'b00, 32'h0,        0, 0);
        tbl[15] = mk(2'b00, 0, 0, 32'h0,        2'b00, 0, 0, 2'b00, 32'h0,        0, 1);

        #1;
        cmp("reset_async_outputs", all_outputs(), 128'd0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
            cmp($sformatf("vec%0d_ctl", i),
                {119'd0, rq_ready, mem_req_valid, rs_valid, outstanding, err_spurious},
                {119'd0, tbl[i].e_rqr, tbl[i].e_mv, tbl[i].e_rsv, tbl[i].e_out, tbl[i].e_err});
            if (tbl[i].e_mv) begin
                exp_fields = tbl[i].e_g ? {1'b1, A1, W1} : {1'b0, A0, W0};
                cmp($sformatf("vec%0d_fields", i), {63'd0, mem_req_we, mem_req_addr, mem_req_data},
                    {63'd0, exp_fields});
            end
            if (tbl[i].e_rsv != 2'b00) begin
                cmp($sformatf("vec%0d_rs_data", i), {96'd0, rs_data}, {96'd0, tbl[i].e_rsd});
            end
        end

        // Reset clears the sticky error; contention then alternates starting at port 0.
        do_reset();
        #1;
        cmp("post_reset_state", all_outputs(), 128'd0);
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b1, (i > 0), 32'(i));
            cmp($sformatf("contend_grant%0d", i), {126'd0, rq_ready},
                {126'd0, ((i % 2) == 0) ? 2'b01 : 2'b10});
            if (i > 0) begin
                cmp($sformatf("contend_resp%0d", i), {126'd0, rs_valid},
                    {126'd0, ((i % 2) == 1) ? 2'b01 : 2'b10});
            end
        end
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        cmp("contend_drain", {126'd0, rs_valid}, {126'd0, 2'b10});
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        cmp("contend_idle_cnt", {125'd0, outstanding}, 128'd0);

        // Back-pressure: port 1 stays granted for three stalled cycles, port 0 follows.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, 32'h0);
            cmp($sformatf("lock_hold%0d", i), {93'd0, rq_ready, mem_req_valid, mem_req_addr},
                {93'd0, 2'b00, 1'b1, A1});
        end
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        cmp("lock_accept", {93'd0, rq_ready, mem_req_valid, mem_req_addr},
            {93'd0, 2'b10, 1'b1, A1});
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        cmp("lock_next_p0", {93'd0, rq_ready, mem_req_valid, mem_req_addr},
            {93'd0, 2'b01, 1'b1, A0});
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        cmp("lock_full", {122'd0, mem_req_valid, rq_ready, outstanding},
            {122'd0, 1'b0, 2'b00, 3'd2});

        // Asynchronous reset with two in flight, then a late response is spurious.
        drive(2'b11, 1'b1, 1'b1, 32'h99);
        cmp("rst_pre_resp", {126'd0, rs_valid}, {126'd0, 2'b10});
        reset = 1'b0;
        #1;
        cmp("rst_async_all_zero", all_outputs(), 128'd0);
        @(negedge clock);
        reset = 1'b1;
        rq_valid = 2'b00; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hAB;
        #1;
        cmp("late_resp_dropped", {125'd0, rs_valid, err_spurious}, 128'd0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        cmp("late_resp_flag", {124'd0, outstanding, err_spurious}, {124'd0, 3'd0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one external memory port between the CPU_RV32IF instruction-fetch requester (port 0) and its data-memory requester (port 1). It performs round-robin arbitration, holds each grant stable until the memory accepts it, and tracks up to MAX_OUTSTANDING in-order transactions. Each response is routed back to the requester that issued it. It sits between the CPU synthesis wrapper and the SoC memory/bus.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions, legal range 1..4.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); deassertion is synchronous to clock upstream.
- rq_valid  in  2  per-requester request valid; bit 0 = fetch, bit 1 = data.
- rq_ready  out  2  per-requester accept, one-hot or zero.
- rq_we  in  2  per-requester write enable; port 0 is always driven 0.
- rq_addr  in  2×ADDR_W  per-requester address.
- rq_wdata  in  2×DATA_W  per-requester write data.
- rs_valid  out  2  per-requester response strobe, one-hot or zero.
- rs_data  out  DATA_W  response data, shared by both requesters.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we, mem_req_addr, mem_req_data  out  1/ADDR_W/DATA_W  muxed request fields.
- mem_resp_valid  in  1  memory response; one per accepted request, writes included, in order.
- mem_resp_data  in  DATA_W  response data.
- outstanding  out  3  current in-flight count.
- err_spurious  out  1  sticky; set by a response arriving while nothing is outstanding.

## Operation
- State:
  - rr_last: last-granted port, reset 1, so port 0 wins the first tie.
  - lock_valid/lock_id: grant held while memory back-pressures.
  - ID FIFO of depth MAX_OUTSTANDING.
  - outstanding counter.
  - err_spurious flag.
- Grant selection, when lock_valid = 0:
  - If both requesters are valid, grant the port ≠ rr_last.
  - If one is valid, grant that port.
  - Selection is combinational from rq_valid.
- Issue:
  - mem_req_valid = (lock_valid | any rq_valid) & (outstanding < MAX_OUTSTANDING).
  - Request fields are muxed from the granted port.
- Handshake: rq_ready[g] = mem_req_valid & mem_req_ready. On handshake:
  - push g into the ID FIFO,
  - set rr_last ← g,
  - clear lock_valid.
- Lock: if mem_req_valid & !mem_req_ready, set lock_valid ← 1 and lock_id ← g.
  - While locked, the grant stays on lock_id regardless of the other port's rq_valid.
  - The requester must hold its fields stable, per the valid/ready rule.
- Response, when mem_resp_valid with FIFO non-empty:
  - rs_valid[head] = 1 and rs_data = mem_resp_data, combinationally;
  - pop the FIFO.
- Spurious response, when mem_resp_valid with FIFO empty: drop it and set err_spurious. Only reset clears the flag.
- Counter update: outstanding += push − pop.
  - A simultaneous push and pop leaves the count unchanged.
  - At full, a same-cycle pop does NOT enable a push: the issue gate uses the registered count.
- Reset values: rq_ready 0, rs_valid 0, rs_data 0, mem_req_valid 0, mem_req_we/addr/data 0, outstanding 0, err_spurious 0, FIFO empty, lock cleared.
- Reset mid-transaction discards in-flight IDs. Late memory responses after reset are therefore flagged spurious.

## Timing
- Request path is zero-latency combinational: rq_valid to mem_req_valid, and mem_req_ready to rq_ready.
- Response path is zero-latency combinational: mem_resp_valid to rs_valid.
- FIFO, counter, lock and rr_last update on the rising clock edge.
- Back-to-back issue is permitted every cycle until outstanding = MAX_OUTSTANDING.
- A fair requester waits at most one competing grant.

## Structure
- Package mem_arb_pkg holds:
  - typedef req_id_t (1 bit),
  - localparams PORT_FETCH = 0 and PORT_DATA = 1,
  - CNT_W = $clog2(MAX_OUTSTANDING+1).
- Sub-module arb_id_fifo: parameterised depth, req_id_t payload, push/pop/full/empty/head, async active-low reset.

## Test plan
- Single fetch: rq_valid = 01, addr 0x100, mem ready, response 0xDEADBEEF one cycle later.
  - Required: rq_ready = 01 in cycle 0; rs_valid = 01 with rs_data = 0xDEADBEEF; outstanding goes 1 then 0.
- Contention: both requesters valid continuously, memory always ready.
  - Required: grants alternate 0, 1, 0, 1; first grant is port 0.
- Back-pressure lock: port 1 valid, mem_req_ready held 0 for 3 cycles, port 0 asserted in cycle 1.
  - Required: grant stays on port 1 with stable addr; port 0 is granted the cycle after port 1's accept.
- Full window, MAX_OUTSTANDING = 2: two accepts with no response.
  - Required: mem_req_valid = 0 while full.
  - In the cycle a response arrives, mem_req_valid is still 0; the next issue happens the following cycle.
  - Responses route in issue order (1 then 0).
- Spurious response and reset: mem_resp_valid while idle.
  - Required: err_spurious = 1 and rs_valid = 00.
  - Assert reset with 2 outstanding: all outputs are 0 immediately, without waiting for a clock edge.
